// File: rtl/max_rect_area_if.sv
// Point-stream and frame-result signals for max_rect_area.
interface max_rect_area_if #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 512
);
    localparam int unsigned AW = $clog2(DEPTH + 1);

    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_x;
    logic [W-1:0]        in_y;
    logic                in_last;
    logic                area_valid;
    logic [2*W+1:0]      area;
    logic [AW-1:0]       count;
    logic                overflow;

    modport master (
        output in_valid, in_x, in_y, in_last,
        input  in_ready, area_valid, area, count, overflow
    );

    modport slave (
        input  in_valid, in_x, in_y, in_last,
        output in_ready, area_valid, area, count, overflow
    );
endinterface

// File: rtl/max_rect_area.sv
// Exact largest inclusive axis-aligned rectangle over all point pairs of a frame.
// Each accepted point is stored, then paired against every stored point
// (itself included) through a read / span / product / max pipeline.
module max_rect_area #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 512
) (
    input  logic           clock,
    input  logic           reset,
    max_rect_area_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);

    typedef enum logic [1:0] {ACCEPT, SCAN, DRAIN, DONE} state_t;

    state_t          state;
    logic            scan_arm;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   scan_end;
    logic            frame_last;
    logic [2:0]      drain_cnt;
    logic [W-1:0]    cur_x;
    logic [W-1:0]    cur_y;

    logic [2*W-1:0]  mem [DEPTH];
    logic [2*W-1:0]  rd_data;
    logic [W-1:0]    rd_x;
    logic [W-1:0]    rd_y;

    logic            rd_v;
    logic            d_v;
    logic            p_v;
    logic [W:0]      dx;
    logic [W:0]      dy;
    logic [2*W+1:0]  prod;
    logic [2*W+1:0]  max_q;
    logic [2*W+1:0]  max_next;

    logic            full;
    logic            accept;
    logic            store;
    logic            rd_issue;

    // Inclusive span |a-b|+1; one extra bit holds 2^W.
    function automatic logic [W:0] span(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return {1'b0, d} + (W+1)'(1);
    endfunction

    assign full     = (bus.count == FULL_CNT);
    assign accept   = (state == ACCEPT) && bus.in_valid;
    assign store    = accept && !full;
    assign rd_issue = (state == SCAN) && scan_arm;
    assign rd_x     = rd_data[2*W-1:W];
    assign rd_y     = rd_data[W-1:0];

    // Running maximum including the product arriving this cycle; ties keep the old value.
    always_comb begin
        max_next = max_q;
        if (p_v && (prod > max_q)) max_next = prod;
    end

    // Point store and synchronous read port; no reset so it can map to block RAM.
    always_ff @(posedge clock) begin
        if (store) mem[bus.count[IW-1:0]] <= {bus.in_x, bus.in_y};
        if (rd_issue) rd_data <= mem[rd_addr[IW-1:0]];
    end

    // Control FSM with registered handshake and result outputs.
    // SCAN spends one setup cycle before the first read so that reads fall in
    // cycles 1..n+1 and ACCEPT resumes in cycle n+2; DRAIN length is counted so
    // the result lands n+5 cycles after a stored last point, 5 after a dropped one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ACCEPT;
            bus.in_ready   <= 1'b1;
            bus.count      <= '0;
            bus.overflow   <= 1'b0;
            bus.area_valid <= 1'b0;
            bus.area       <= '0;
            scan_arm       <= 1'b0;
            rd_addr        <= '0;
            scan_end       <= '0;
            frame_last     <= 1'b0;
            drain_cnt      <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
        end else begin
            bus.area_valid <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (accept) begin
                        if (full) begin
                            bus.overflow <= 1'b1;
                            if (bus.in_last) begin
                                state        <= DRAIN;
                                drain_cnt    <= 3'd4;
                                bus.in_ready <= 1'b0;
                            end
                        end else begin
                            cur_x        <= bus.in_x;
                            cur_y        <= bus.in_y;
                            frame_last   <= bus.in_last;
                            scan_end     <= bus.count;
                            bus.count    <= bus.count + AW'(1);
                            rd_addr      <= '0;
                            scan_arm     <= 1'b0;
                            state        <= SCAN;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (!scan_arm) begin
                        scan_arm <= 1'b1;
                    end else if (rd_addr == scan_end) begin
                        scan_arm <= 1'b0;
                        if (frame_last) begin
                            state     <= DRAIN;
                            drain_cnt <= 3'd2;
                        end else begin
                            state        <= ACCEPT;
                            bus.in_ready <= 1'b1;
                        end
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state          <= DONE;
                        bus.area       <= max_next;
                        bus.area_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                DONE: begin
                    state        <= ACCEPT;
                    bus.in_ready <= 1'b1;
                    bus.count    <= '0;
                    bus.overflow <= 1'b0;
                end
                default: state <= ACCEPT;
            endcase
        end
    end

    // Datapath pipeline: read data -> spans -> product -> max register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_v  <= 1'b0;
            d_v   <= 1'b0;
            p_v   <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            prod  <= '0;
            max_q <= '0;
        end else begin
            rd_v <= rd_issue;
            d_v  <= rd_v;
            p_v  <= d_v;
            if (rd_v) begin
                dx <= span(rd_x, cur_x);
                dy <= span(rd_y, cur_y);
            end
            if (d_v) prod <= (2*W+2)'(dx) * (2*W+2)'(dy);
            if (state == DONE) max_q <= '0;
            else               max_q <= max_next;
        end
    end
endmodule

// File: tb/tb_max_rect_area.sv
// Directed bench for max_rect_area: two instances (DEPTH 512 and DEPTH 4).
module tb_max_rect_area;
    localparam int unsigned W = 17;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    max_rect_area_if #(.W(W), .DEPTH(512)) bus  ();
    max_rect_area_if #(.W(W), .DEPTH(4))   bus4 ();

    max_rect_area #(.W(W), .DEPTH(512)) dut  (.clock(clock), .reset(reset), .bus(bus));
    max_rect_area #(.W(W), .DEPTH(4))   dut4 (.clock(clock), .reset(reset), .bus(bus4));

    logic          sel;
    logic          v;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          last;

    assign bus.in_valid  = v && !sel;
    assign bus.in_x      = x;
    assign bus.in_y      = y;
    assign bus.in_last   = last;
    assign bus4.in_valid = v && sel;
    assign bus4.in_x     = x;
    assign bus4.in_y     = y;
    assign bus4.in_last  = last;

    logic            o_ready;
    logic            o_av;
    logic [2*W+1:0]  o_area;
    logic [9:0]      o_count;
    logic            o_ovf;
    assign o_ready = sel ? bus4.in_ready   : bus.in_ready;
    assign o_av    = sel ? bus4.area_valid : bus.area_valid;
    assign o_area  = sel ? bus4.area       : bus.area;
    assign o_count = sel ? 10'(bus4.count) : bus.count;
    assign o_ovf   = sel ? bus4.overflow   : bus.overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int px[8];
    int py[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one point after an optional idle gap; returns just after its accept edge.
    task automatic send(input int xx, input int yy, input bit lst, input int gap);
        int t;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        v = 1'b1; x = W'(xx); y = W'(yy); last = lst;
        t = 0;
        while (!o_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) check("send_timeout", 64'(t), 64'(0));
        @(posedge clock);
        #1;
        v = 1'b0; last = 1'b0;
    endtask

    // Cycle index (0 = cycle right after the accept edge) where in_ready is first high.
    task automatic wait_ready(output int k);
        k = 0;
        @(negedge clock);
        while (!o_ready && k < 100) begin
            k++;
            @(negedge clock);
        end
    endtask

    // Cycle index where area_valid is first high.
    task automatic wait_area(output int k);
        k = 0;
        @(negedge clock);
        while (!o_av && k < 100) begin
            k++;
            @(negedge clock);
        end
    endtask

    task automatic run_frame(input int np, input int depth, input int maxgap,
                             input logic [63:0] exp_area, input string tag);
        int k;
        int gap;
        for (int i = 0; i < np; i++) begin
            gap = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
            send(px[i], py[i], i == np - 1, gap);
            if (i < np - 1) begin
                wait_ready(k);
                check({tag, "_ready_lat"}, 64'(k), 64'((i < depth) ? i + 2 : 0));
            end
        end
        wait_area(k);
        check({tag, "_area_lat"}, 64'(k), 64'((np - 1 < depth) ? np + 4 : 5));
        check({tag, "_area"}, 64'(o_area), exp_area);
    endtask

    // Result period and the cycle after it: single pulse, counters cleared, area held.
    task automatic after_result(input logic [63:0] exp_area, input string tag);
        check({tag, "_ready_in_done"}, 64'(o_ready), 64'(0));
        @(negedge clock);
        check({tag, "_pulse_end"}, 64'(o_av), 64'(0));
        check({tag, "_count_clr"}, 64'(o_count), 64'(0));
        check({tag, "_ovf_clr"}, 64'(o_ovf), 64'(0));
        check({tag, "_ready_back"}, 64'(o_ready), 64'(1));
        repeat (5) @(negedge clock);
        check({tag, "_area_hold"}, 64'(o_area), exp_area);
    endtask

    initial begin
        int k;
        reset = 1'b1; sel = 1'b0; v = 1'b0; x = '0; y = '0; last = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", 64'(bus.in_ready), 64'(1));
        check("rst_av", 64'(bus.area_valid), 64'(0));
        check("rst_area", 64'(bus.area), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        check("rst_ovf", 64'(bus.overflow), 64'(0));
        check("rst_ready4", 64'(bus4.in_ready), 64'(1));
        reset = 1'b0;

        // Eight-point outline, max 50 from (2,3)-(11,7) or (2,5)-(11,1).
        px = '{7, 11, 11, 9, 9, 2, 2, 7};
        py = '{1, 1, 7, 7, 5, 5, 3, 3};
        run_frame(8, 512, 0, 64'd50, "outline");
        check("outline_count_at_result", 64'(o_count), 64'(8));
        after_result(64'd50, "outline");

        // Single point pairs with itself.
        px[0] = 5; py[0] = 5;
        run_frame(1, 512, 0, 64'd1, "single");
        after_result(64'd1, "single");

        // Full-range corners: 131072 * 131072 = 2^34.
        px[0] = 0; py[0] = 0; px[1] = 131071; py[1] = 131071;
        run_frame(2, 512, 0, 64'd17179869184, "wide");
        after_result(64'd17179869184, "wide");

        // Reset in the middle of the third point's scan.
        send(10, 10, 1'b0, 0); wait_ready(k);
        send(20, 20, 1'b0, 0); wait_ready(k);
        send(30, 30, 1'b0, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_ready", 64'(bus.in_ready), 64'(1));
        check("midrst_count", 64'(bus.count), 64'(0));
        check("midrst_area", 64'(bus.area), 64'(0));
        check("midrst_av", 64'(bus.area_valid), 64'(0));
        check("midrst_ovf", 64'(bus.overflow), 64'(0));
        repeat (6) @(negedge clock);
        check("midrst_no_pulse", 64'(bus.area_valid), 64'(0));
        reset = 1'b0;
        px[0] = 0; py[0] = 0; px[1] = 3; py[1] = 1;
        run_frame(2, 512, 0, 64'd8, "postrst");
        after_result(64'd8, "postrst");

        // Same outline with random idle gaps between points.
        px = '{7, 11, 11, 9, 9, 2, 2, 7};
        py = '{1, 1, 7, 7, 5, 5, 3, 3};
        run_frame(8, 512, 3, 64'd50, "gaps");
        after_result(64'd50, "gaps");

        // DEPTH 4: last two far-apart points are dropped; max over first four is (0,0)-(3,2) = 12.
        sel = 1'b1;
        px = '{0, 2, 1, 3, 100, 1000, 0, 0};
        py = '{0, 1, 3, 2, 100, 0, 0, 0};
        run_frame(6, 4, 0, 64'd12, "depth4");
        check("depth4_ovf", 64'(o_ovf), 64'(1));
        check("depth4_count", 64'(o_count), 64'(4));
        after_result(64'd12, "depth4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
